fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//   Round-robin arbiter sharing the write port of asynch_fifo_top among NREQ requesters.
//   Lives entirely in the write-clock domain; drives winc/wdata and obeys full.
//   Grants bursts of up to BURST words per requester.
//   Removes per-source write muxing from the producers.
// PARAMETERS
//   NREQ   4  number of requesters (>=2)
//   DSIZE  8  data width; must match FIFO dsize
//   BURST  4  max words accepted per grant before re-arbitration (>=1)
// PORTS
//   wclk      in   1           write-side clock; the only clock
//   wrst_n    in   1           asynchronous, active-low reset
//   req       in   NREQ        req[i]=1: requester i has a valid word on its req_data slice
//   req_data  in   NREQ*DSIZE  word of requester i at [i*DSIZE +: DSIZE]
//   full      in   1           FIFO full flag (wclk domain)
//   ack       out  NREQ        one-hot; ack[i]=1: requester i's word written this edge
//   gnt       out  NREQ        one-hot current owner; 0 when IDLE
//   winc      out  1           FIFO write enable
//   wdata     out  DSIZE       FIFO write data
//   busy      out  1           1 while in GRANT
// BEHAVIOUR
//   Reset (async, wrst_n=0): state=IDLE, owner=0, last=NREQ-1, cnt=0.
//     Outputs forced to winc=0, ack=0, gnt=0, busy=0 without waiting for wclk.
//   FSM with two states: IDLE, GRANT.
//     IDLE:  if |req, owner<=rr_pick(req,last), cnt<=0, go to GRANT. Costs one arbitration cycle.
//     GRANT: accept = req[owner] & ~full.
//       On accept, cnt<=cnt+1.
//       Release when ~req[owner], or when accept & cnt==BURST-1.
//       On release, last<=owner. If |req_next, owner<=rr_pick(req,owner), cnt<=0, stay in GRANT
//       (no bubble); otherwise go to IDLE.
//       req_next is req with the owner's bit cleared when the release was caused by ~req[owner].
//   rr_pick searches from last+1 upward with wrap-around, so last is checked last.
//     A sole requester is therefore re-granted back-to-back.
//   Combinational from registered state:
//     winc  = GRANT & req[owner] & ~full
//     wdata = req_data[owner]
//     ack   = winc ? onehot(owner) : 0
//     gnt   = GRANT ? onehot(owner) : 0
//   Latency: req rises at edge N (IDLE) -> gnt at N+1 -> first write at edge N+2.
//   Full: winc=0 and ack=0 while full=1; owner and cnt hold.
//     Full cycles do not count toward BURST and never cause a release.
//   Requester protocol: hold req and data stable until ack.
//     After ack, present the next word or drop req on the following cycle.
//     Dropping req without ack withdraws the word; nothing is written.
//   Simultaneous: a new req arriving in a release cycle takes part in that same re-arbitration.
//   No write occurs while wrst_n=0. After reset the first grant goes to the lowest index requesting.
// CONFIGURATION
//   FIFO_ARB_PRIO_EN defined: requester 0 wins every arbitration in which req[0]=1.
//     It never preempts a running burst.
//     Its release still updates last, but rr_pick is overridden whenever req[0]=1.
//   FIFO_ARB_PRIO_EN undefined: pure round-robin as above.
// STRUCTURE
//   Package fifo_arb_pkg holds:
//     typedef enum logic {IDLE, GRANT} arb_state_t
//     localparam helper for $clog2(NREQ) owner width
//     localparam helper for $clog2(BURST) count width
//   Sub-module rr_pick: combinational rotate-priority encoder.
//     Inputs: req and start index. Outputs: index and found flag.
//   The FSM, counter and output muxing stay in fifo_write_arbiter.
// TESTING
//   1. Assert wrst_n=0 mid-burst with req=4'b1111 -> winc/gnt/ack drop to 0 immediately.
//      After release, the first gnt is 4'b0001.
//   2. Only req[2] set, 6 words 0x10..0x15, BURST=4 -> wdata 0x10..0x15 on 6 consecutive edges.
//      Bubble-free re-grant to requester 2 after the 4th word.
//   3. req=4'b1111 held -> grant order 0,1,2,3,0; exactly 4 acks each; winc never drops between bursts.
//   4. full=1 for 3 cycles after owner's 2nd word -> winc=0 and ack=0 for those 3 cycles.
//      Burst resumes and completes 4 words total.
//   5. Drive 16-deep FIFO from req[1] with 20 words, no reads.
//      -> exactly 16 writes, then winc stays 0 while full=1; FIFO contents match in order.
//   6. FIFO_ARB_PRIO_EN defined, owner 0 releases with req[0]=req[3]=1 -> next owner 0.
//      Undefined: next owner 3.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    // Arbiter FSM states; also exported on the debug path.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Default configuration.
    localparam int NREQ_DEF  = 4;
    localparam int DSIZE_DEF = 8;
    localparam int BURST_DEF = 4;

    // Width of an owner index (at least one bit).
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of the burst counter that counts 0..burst-1 (at least one bit).
    function automatic int count_width(input int burst);
        return (burst > 1) ? $clog2(burst) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Bundle between the requesters, the FIFO write port and the arbiter.
//
// Handshake: req[i] is requester i's valid and is paired with its req_data
// slice. The arbiter writes the word, and pulses ack[i] (the ready), on a
// clock edge where winc=1. A word is transferred only on an edge where
// req[i] and ack[i] are both 1. The requester holds req and data stable
// until it sees ack. It then presents the next word or drops req. Dropping
// req before ack withdraws the word. full=1 blocks every transfer.
interface fifo_write_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
);
    import fifo_arb_pkg::*;

    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] req_data;
    logic                  full;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       gnt;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic                  busy;
    arb_state_t            state;   // debug view of the arbiter FSM

    modport master (
        input  req, req_data, full,
        output ack, gnt, winc, wdata, busy, state
    );

    modport slave (
        output req, req_data, full,
        input  ack, gnt, winc, wdata, busy, state
    );

endinterface

// File: rtl/rr_pick.sv
// Rotate-priority encoder. It searches req from start+1 upward with
// wrap-around, so index 'start' has the lowest priority.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   start_i,
    output logic [IW-1:0]   idx_o,
    output logic            found_o
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IW:0]       sum;
    logic              hit;

    // Rotate so that bit 0 is start+1, then take the first set bit.
    always_comb begin
        dbl     = {req_i, req_i};
        rot     = NREQ'(dbl >> ({1'b0, start_i} + 1'b1));
        sum     = '0;
        hit     = 1'b0;
        idx_o   = '0;
        found_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!hit && rot[k]) begin
                hit = 1'b1;
                sum = {1'b0, start_i} + (IW+1)'(k + 1);
                if (sum >= (IW+1)'(NREQ)) begin
                    sum = sum - (IW+1)'(NREQ);
                end
                idx_o   = IW'(sum);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NREQ producers.
// It grants bursts of up to BURST words and re-arbitrates without a bubble.
// Optional feature: define FIFO_ARB_PRIO_EN to make requester 0 win every
// arbitration in which it requests. A running burst is never preempted.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int DSIZE = DSIZE_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    fifo_write_arbiter_if.master bus
);

    localparam int            IW       = owner_width(NREQ);
    localparam int            CW       = count_width(BURST);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NREQ-1:0]  owner_oh;
    logic [NREQ-1:0]  req_next;
    logic [NREQ-1:0]  pick_req;
    logic [IW-1:0]    pick_start;
    logic [IW-1:0]    rr_idx;
    logic [IW-1:0]    pick_idx;
    logic             rr_found;
    logic             owner_req;
    logic             accept;
    logic             rel;
    logic [DSIZE-1:0] words [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign words[g] = bus.req_data[g*DSIZE +: DSIZE];
    end

    assign owner_oh  = NREQ'(1) << owner_q;
    assign owner_req = bus.req[owner_q];
    assign accept    = (state_q == GRANT) && owner_req && !bus.full;
    // A burst ends when the owner withdraws or its last allowed word is written.
    assign rel       = (state_q == GRANT) &&
                       (!owner_req || (accept && (cnt_q == CNT_LAST)));
    // A withdrawing owner must not win the re-arbitration it causes.
    assign req_next  = owner_req ? bus.req : (bus.req & ~owner_oh);

    // Select what is arbitrated. IDLE rotates from the last owner.
    // A release in GRANT rotates from the current owner.
    always_comb begin
        pick_req   = bus.req;
        pick_start = last_q;
        if (state_q == GRANT) begin
            pick_req   = req_next;
            pick_start = owner_q;
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req_i   (pick_req),
        .start_i (pick_start),
        .idx_o   (rr_idx),
        .found_o (rr_found)
    );

`ifdef FIFO_ARB_PRIO_EN
    // Requester 0 overrides the rotation whenever it takes part.
    assign pick_idx = pick_req[0] ? '0 : rr_idx;
`else
    assign pick_idx = rr_idx;
`endif

    // State, owner, last-owner and burst-count registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: arbitration in IDLE, then burst counting and release in GRANT.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    owner_d = pick_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (rel) begin
                    last_d = owner_q;
                    cnt_d  = '0;
                    if (rr_found) begin
                        owner_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.winc  = accept;
    assign bus.wdata = words[owner_q];
    assign bus.ack   = accept ? owner_oh : '0;
    assign bus.gnt   = (state_q == GRANT) ? owner_oh : '0;
    assign bus.busy  = (state_q == GRANT);
    assign bus.state = state_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter. Each requester owns a word list.
// A word is popped when the arbiter acks it. Every write is checked against
// a hand-built expected queue.
module tb_fifo_write_arbiter;
    import fifo_arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;
    localparam int BURST = 4;
    localparam int DEPTH = 16;

    logic wclk = 1'b0;
    logic wrst_n;

    logic [NREQ-1:0]       req_v;
    logic [NREQ*DSIZE-1:0] req_data_v;
    logic                  full_drv;
    logic                  use_fifo;
    int                    fifo_cnt;
    logic [DSIZE-1:0]      fifo_mem [DEPTH];

    logic [DSIZE-1:0] src_mem  [NREQ][32];
    int               src_head [NREQ];
    int               src_tail [NREQ];

    logic [DSIZE-1:0] exp_q [$];
    logic             winc_log [$];
    logic [NREQ-1:0]  gnt_log [$];
    logic [NREQ-1:0]  ack_log [$];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    fifo_write_arbiter_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

    assign bus.req      = req_v;
    assign bus.req_data = req_data_v;
    assign bus.full     = use_fifo ? (fifo_cnt >= DEPTH) : full_drv;

    fifo_write_arbiter #(
        .NREQ  (NREQ),
        .DSIZE (DSIZE),
        .BURST (BURST)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    // Clock and reset
    always #5 wclk = ~wclk;

    task automatic do_reset();
        wrst_n   = 1'b0;
        full_drv = 1'b0;
        use_fifo = 1'b0;
        fifo_cnt = 0;
        for (int i = 0; i < NREQ; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        req_v      = '0;
        req_data_v = '0;
        exp_q.delete();
        winc_log.delete();
        gnt_log.delete();
        ack_log.delete();
        @(posedge wclk);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
    endtask

    // Driver tasks
    task automatic push_word(input int r, input logic [DSIZE-1:0] d);
        src_mem[r][src_tail[r]] = d;
        src_tail[r]++;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NREQ; i++) begin
            req_v[i] = (src_head[i] < src_tail[i]);
            req_data_v[i*DSIZE +: DSIZE] = req_v[i] ? src_mem[i][src_head[i]] : '0;
        end
    endtask

    // One clock cycle: present inputs, sample and score the outputs, pass the
    // edge, then retire acked words.
    task automatic drive_cycle();
        logic [NREQ-1:0]  a;
        logic             w;
        logic [DSIZE-1:0] d;
        logic [DSIZE-1:0] e;
        apply_inputs();
        #1;
        w = bus.winc;
        a = bus.ack;
        d = bus.wdata;
        winc_log.push_back(w);
        gnt_log.push_back(bus.gnt);
        ack_log.push_back(a);
        if (w) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL write_unexpected: got wdata=%h, required no write", d);
            end else begin
                e = exp_q.pop_front();
                if (d !== e) $display("FAIL write_data: got %h, required %h", d, e);
                else pass_cnt++;
            end
        end
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (a[i]) src_head[i]++;
        end
        if (w && use_fifo && fifo_cnt < DEPTH) begin
            fifo_mem[fifo_cnt] = d;
            fifo_cnt++;
        end
    endtask

    task automatic check_drained(input string name);
        chk_cnt++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drained: got %0d words still expected, required 0", name, exp_q.size());
        else pass_cnt++;
    endtask

    // Scenarios
    task automatic test_reset();
        wrst_n     = 1'b0;
        req_v      = '1;
        req_data_v = '0;
        full_drv   = 1'b0;
        use_fifo   = 1'b0;
        fifo_cnt   = 0;
        #2;
        chk_cnt++; if (bus.winc !== 1'b0) $display("FAIL rst_winc: got %b, required 0", bus.winc); else pass_cnt++;
        chk_cnt++; if (bus.gnt !== 4'b0000) $display("FAIL rst_gnt: got %b, required 0000", bus.gnt); else pass_cnt++;
        chk_cnt++; if (bus.ack !== 4'b0000) $display("FAIL rst_ack: got %b, required 0000", bus.ack); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", bus.busy); else pass_cnt++;
        chk_cnt++; if (bus.state !== IDLE) $display("FAIL rst_state: got %b, required IDLE", bus.state); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 8; k++) push_word(i, DSIZE'(i*16 + k));
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h01);
        repeat (3) drive_cycle();
        apply_inputs();
        #1;
        chk_cnt++;
        if (bus.winc !== 1'b1 || bus.gnt !== 4'b0001)
            $display("FAIL mid_burst: got winc=%b gnt=%b, required winc=1 gnt=0001", bus.winc, bus.gnt);
        else pass_cnt++;
        wrst_n = 1'b0;
        #1;
        chk_cnt++; if (bus.winc !== 1'b0) $display("FAIL arst_winc: got %b, required 0", bus.winc); else pass_cnt++;
        chk_cnt++; if (bus.gnt !== 4'b0000) $display("FAIL arst_gnt: got %b, required 0000", bus.gnt); else pass_cnt++;
        chk_cnt++; if (bus.ack !== 4'b0000) $display("FAIL arst_ack: got %b, required 0000", bus.ack); else pass_cnt++;
        chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL arst_busy: got %b, required 0", bus.busy); else pass_cnt++;
        #2;
        wrst_n = 1'b1;
        #1;
        chk_cnt++; if (bus.gnt !== 4'b0000) $display("FAIL idle_after_rst: got gnt=%b, required 0000", bus.gnt); else pass_cnt++;
        @(posedge wclk);
        #1;
        gnt_log.delete();
        exp_q.push_back(8'h02);
        drive_cycle();
        chk_cnt++; if (gnt_log[0] !== 4'b0001) $display("FAIL first_gnt: got %b, required 0001", gnt_log[0]); else pass_cnt++;
        check_drained("async_reset");
    endtask

    task automatic test_back_to_back();
        logic [8:0] ew;
        ew = 9'b001111110;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            push_word(2, DSIZE'(8'h10 + k));
            exp_q.push_back(DSIZE'(8'h10 + k));
        end
        repeat (9) drive_cycle();
        for (int c = 0; c < 9; c++) begin
            chk_cnt++;
            if (winc_log[c] !== ew[c]) $display("FAIL b2b_winc_c%0d: got %b, required %b", c, winc_log[c], ew[c]);
            else pass_cnt++;
        end
        chk_cnt++; if (gnt_log[5] !== 4'b0100) $display("FAIL b2b_regrant: got %b, required 0100", gnt_log[5]); else pass_cnt++;
        chk_cnt++; if (gnt_log[8] !== 4'b0000) $display("FAIL b2b_idle: got %b, required 0000", gnt_log[8]); else pass_cnt++;
        check_drained("b2b");
    endtask

    task automatic test_round_robin();
        int acks [NREQ];
        logic all_w;
        do_reset();
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < NREQ; i++) push_word(i, DSIZE'(i*16 + k));
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < 4; k++) exp_q.push_back(DSIZE'(i*16 + k));
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h14);
        exp_q.push_back(8'h24);
        exp_q.push_back(8'h34);
        repeat (26) drive_cycle();
        chk_cnt++; if (gnt_log[1]  !== 4'b0001) $display("FAIL rr_gnt_1: got %b, required 0001", gnt_log[1]); else pass_cnt++;
        chk_cnt++; if (gnt_log[5]  !== 4'b0010) $display("FAIL rr_gnt_2: got %b, required 0010", gnt_log[5]); else pass_cnt++;
        chk_cnt++; if (gnt_log[9]  !== 4'b0100) $display("FAIL rr_gnt_3: got %b, required 0100", gnt_log[9]); else pass_cnt++;
        chk_cnt++; if (gnt_log[13] !== 4'b1000) $display("FAIL rr_gnt_4: got %b, required 1000", gnt_log[13]); else pass_cnt++;
        chk_cnt++; if (gnt_log[17] !== 4'b0001) $display("FAIL rr_gnt_5: got %b, required 0001", gnt_log[17]); else pass_cnt++;
        all_w = 1'b1;
        for (int c = 1; c <= 17; c++) all_w = all_w & winc_log[c];
        chk_cnt++; if (all_w !== 1'b1) $display("FAIL rr_no_bubble: got %b, required 1", all_w); else pass_cnt++;
        for (int i = 0; i < NREQ; i++) acks[i] = 0;
        for (int c = 1; c <= 16; c++)
            for (int i = 0; i < NREQ; i++) if (ack_log[c][i]) acks[i]++;
        for (int i = 0; i < NREQ; i++) begin
            chk_cnt++;
            if (acks[i] != BURST) $display("FAIL rr_acks_%0d: got %0d, required %0d", i, acks[i], BURST);
            else pass_cnt++;
        end
        check_drained("rr");
    endtask

    task automatic test_full_stall();
        logic [12:0] ew;
        ew = 13'b0110111000110;
        do_reset();
        for (int k = 0; k < 6; k++) push_word(1, DSIZE'(8'h10 + k));
        push_word(3, 8'h30);
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h30, 8'h14, 8'h15};
        for (int c = 0; c < 13; c++) begin
            full_drv = (c >= 3 && c <= 5);
            drive_cycle();
        end
        full_drv = 1'b0;
        for (int c = 0; c < 13; c++) begin
            chk_cnt++;
            if (winc_log[c] !== ew[c]) $display("FAIL full_winc_c%0d: got %b, required %b", c, winc_log[c], ew[c]);
            else pass_cnt++;
        end
        for (int c = 3; c <= 5; c++) begin
            chk_cnt++;
            if (ack_log[c] !== 4'b0000 || gnt_log[c] !== 4'b0010)
                $display("FAIL full_hold_c%0d: got ack=%b gnt=%b, required ack=0000 gnt=0010", c, ack_log[c], gnt_log[c]);
            else pass_cnt++;
        end
        chk_cnt++; if (gnt_log[8] !== 4'b1000) $display("FAIL full_burst_end: got %b, required 1000", gnt_log[8]); else pass_cnt++;
        check_drained("full");
    endtask

    task automatic test_fifo_fill();
        logic late_w;
        do_reset();
        use_fifo = 1'b1;
        for (int k = 0; k < 20; k++) push_word(1, DSIZE'(8'h40 + k));
        for (int k = 0; k < DEPTH; k++) exp_q.push_back(DSIZE'(8'h40 + k));
        repeat (30) drive_cycle();
        chk_cnt++; if (fifo_cnt != DEPTH) $display("FAIL fill_count: got %0d, required %0d", fifo_cnt, DEPTH); else pass_cnt++;
        for (int k = 0; k < DEPTH; k += 5) begin
            chk_cnt++;
            if (fifo_mem[k] !== DSIZE'(8'h40 + k))
                $display("FAIL fill_mem_%0d: got %h, required %h", k, fifo_mem[k], DSIZE'(8'h40 + k));
            else pass_cnt++;
        end
        late_w = 1'b0;
        for (int c = 17; c < 30; c++) late_w = late_w | winc_log[c];
        chk_cnt++; if (late_w !== 1'b0) $display("FAIL fill_winc_full: got %b, required 0", late_w); else pass_cnt++;
        chk_cnt++; if (gnt_log[20] !== 4'b0010) $display("FAIL fill_owner_hold: got %b, required 0010", gnt_log[20]); else pass_cnt++;
        check_drained("fill");
        use_fifo = 1'b0;
    endtask

    task automatic test_prio();
        logic [NREQ-1:0] eg;
        do_reset();
        for (int k = 0; k < 5; k++) push_word(0, DSIZE'(k));
        push_word(3, 8'h30);
`ifdef FIFO_ARB_PRIO_EN
        eg    = 4'b0001;
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h30};
`else
        eg    = 4'b1000;
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h30, 8'h04};
`endif
        repeat (10) drive_cycle();
        chk_cnt++; if (gnt_log[5] !== eg) $display("FAIL prio_next_owner: got %b, required %b", gnt_log[5], eg); else pass_cnt++;
        check_drained("prio");
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_async_reset();
        test_back_to_back();
        test_round_robin();
        test_full_stall();
        test_fifo_fill();
        test_prio();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
